// File: rtl/dds_fir_decim_if.sv
// Sample stream bus for the DDS decimating FIR: raw DDS samples in, filtered samples out.
interface dds_fir_decim_if;
  logic        [9:0] din;
  logic              din_en;
  logic              clr;
  logic signed [9:0] dout;
  logic              dout_en;

  modport master (
    output din, din_en, clr,
    input  dout, dout_en
  );

  modport slave (
    input  din, din_en, clr,
    output dout, dout_en
  );
endinterface

// File: rtl/dds_fir_decim.sv
// 8-tap symmetric FIR (2,4,8,18,18,8,4,2)/64 on DDS samples, followed by
// decimation by DECIM. Three-stage pipeline: pre-add, multiply-accumulate,
// round. Only the samples chosen by the decimation counter travel with valid=1.
module dds_fir_decim #(
  parameter int DECIM = 4
) (
  input  logic           clk,
  input  logic           rst,
  dds_fir_decim_if.slave bus
);

  localparam int DATA_W = 10;
  localparam int PRE_W  = DATA_W + 1;
  localparam int ACC_W  = 17;
  localparam logic [3:0] CNT_LAST = 4'(DECIM - 1);

  logic signed [DATA_W-1:0] x_in;
  logic signed [DATA_W-1:0] dly_q [8];
  logic signed [DATA_W-1:0] dly_d [8];
  logic        [3:0]        cnt_q, cnt_d;
  logic                     vld_p0_q, vld_p0_d;
  logic signed [PRE_W-1:0]  pre_p1_q [4];
  logic signed [PRE_W-1:0]  pre_p1_d [4];
  logic                     vld_p1_q, vld_p1_d;
  logic signed [ACC_W-1:0]  acc_p2_q, acc_p2_d;
  logic                     vld_p2_q, vld_p2_d;
  logic signed [DATA_W-1:0] dout_q, dout_d;
  logic                     dout_en_q, dout_en_d;

  // Sum of a symmetric tap pair; one extra bit holds the full range.
  function automatic logic signed [PRE_W-1:0] pre_add(input logic signed [DATA_W-1:0] a,
                                                      input logic signed [DATA_W-1:0] b);
    logic signed [PRE_W-1:0] ea, eb;
    ea = {a[DATA_W-1], a};
    eb = {b[DATA_W-1], b};
    return ea + eb;
  endfunction

  // Weighted sum of the four pair sums; 17 bits holds +-32*1024 exactly.
  function automatic logic signed [ACC_W-1:0] mac(input logic signed [PRE_W-1:0] p0,
                                                  input logic signed [PRE_W-1:0] p1,
                                                  input logic signed [PRE_W-1:0] p2,
                                                  input logic signed [PRE_W-1:0] p3);
    logic signed [ACC_W-1:0] e0, e1, e2, e3;
    e0 = {{(ACC_W-PRE_W){p0[PRE_W-1]}}, p0};
    e1 = {{(ACC_W-PRE_W){p1[PRE_W-1]}}, p1};
    e2 = {{(ACC_W-PRE_W){p2[PRE_W-1]}}, p2};
    e3 = {{(ACC_W-PRE_W){p3[PRE_W-1]}}, p3};
    return (e0 <<< 1) + (e1 <<< 2) + (e2 <<< 3) + (e3 * 17'sd18);
  endfunction

  // Divide by the coefficient sum 64, rounding half up. The accumulator is
  // bounded by +-32768 so the quotient always fits 10 bits; no clamp needed.
  function automatic logic signed [DATA_W-1:0] round_acc(input logic signed [ACC_W-1:0] a);
    logic signed [ACC_W-1:0] s, sh;
    s  = a + 17'sd32;
    sh = s >>> 6;
    return sh[DATA_W-1:0];
  endfunction

  // Next-state for delay line, decimation phase and every pipeline stage.
  always_comb begin
    x_in     = $signed({~bus.din[9], bus.din[8:0]});
    dly_d    = dly_q;
    cnt_d    = cnt_q;
    vld_p0_d = 1'b0;

    // Stage 0: delay line shift and decimation selection
    if (bus.clr) begin
      for (int i = 0; i < 8; i++) dly_d[i] = '0;
      cnt_d = '0;
    end else if (bus.din_en) begin
      dly_d[0] = x_in;
      for (int i = 7; i > 0; i--) dly_d[i] = dly_q[i-1];
      vld_p0_d = (cnt_q == CNT_LAST);
      cnt_d    = (cnt_q == CNT_LAST) ? 4'd0 : cnt_q + 4'd1;
    end

    // Stage 1: symmetric pre-add
    pre_p1_d[0] = pre_add(dly_q[0], dly_q[7]);
    pre_p1_d[1] = pre_add(dly_q[1], dly_q[6]);
    pre_p1_d[2] = pre_add(dly_q[2], dly_q[5]);
    pre_p1_d[3] = pre_add(dly_q[3], dly_q[4]);
    vld_p1_d    = vld_p0_q & ~bus.clr;

    // Stage 2: coefficient weighting and accumulate
    acc_p2_d = mac(pre_p1_q[0], pre_p1_q[1], pre_p1_q[2], pre_p1_q[3]);
    vld_p2_d = vld_p1_q & ~bus.clr;

    // Stage 3: round to output; dout holds between strobes and across a flush
    dout_en_d = vld_p2_q & ~bus.clr;
    dout_d    = dout_en_d ? round_acc(acc_p2_q) : dout_q;
  end

  // State registers; arithmetic stage data carries no reset, its valid bit guards it.
  always_ff @(posedge clk) begin
    pre_p1_q <= pre_p1_d;
    acc_p2_q <= acc_p2_d;
    if (rst) begin
      for (int i = 0; i < 8; i++) dly_q[i] <= '0;
      cnt_q     <= '0;
      vld_p0_q  <= 1'b0;
      vld_p1_q  <= 1'b0;
      vld_p2_q  <= 1'b0;
      dout_q    <= '0;
      dout_en_q <= 1'b0;
    end else begin
      dly_q     <= dly_d;
      cnt_q     <= cnt_d;
      vld_p0_q  <= vld_p0_d;
      vld_p1_q  <= vld_p1_d;
      vld_p2_q  <= vld_p2_d;
      dout_q    <= dout_d;
      dout_en_q <= dout_en_d;
    end
  end

  assign bus.dout    = dout_q;
  assign bus.dout_en = dout_en_q;

endmodule

// File: tb/tb_dds_fir_decim.sv
// Bench for dds_fir_decim: one instance with DECIM=1 and one with DECIM=4 share
// a directed stimulus; a convolution model predicts both outputs every cycle.
module tb_dds_fir_decim;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] din;
  logic       din_en;
  logic       clr;

  always #5 clk = ~clk;

  dds_fir_decim_if bus1 ();
  dds_fir_decim_if bus4 ();

  assign bus1.din    = din;
  assign bus1.din_en = din_en;
  assign bus1.clr    = clr;
  assign bus4.din    = din;
  assign bus4.din_en = din_en;
  assign bus4.clr    = clr;

  dds_fir_decim #(.DECIM(1)) u_d1 (.clk(clk), .rst(rst), .bus(bus1.slave));
  dds_fir_decim #(.DECIM(4)) u_d4 (.clk(clk), .rst(rst), .bus(bus4.slave));

  // Model state: per instance, the accepted-sample history and a schedule of
  // outputs keyed by the edge they must appear after.
  int coef [8] = '{2, 4, 8, 18, 18, 8, 4, 2};
  int decim [2] = '{1, 4};
  int hist [2][8];
  int cnt [2];
  bit sch_f [2][4];
  int sch_v [2][4];
  int last [2];
  int exp_en [2];
  int exp_dout [2];
  int cyc = 0;
  bit armed = 1'b0;

  int n_chk = 0;
  int n_fail = 0;
  int cap1 [$];
  int cap4 [$];
  int capc1 [$];

  function automatic int filt(input int d);
    int s = 0;
    for (int i = 0; i < 8; i++) s += coef[i] * hist[d][i];
    return (s + 32) >>> 6;
  endfunction

  // Model update at each rising edge from the inputs presented to it.
  always @(posedge clk) begin
    cyc++;
    for (int d = 0; d < 2; d++) begin
      if (rst || clr) begin
        for (int i = 0; i < 8; i++) hist[d][i] = 0;
        for (int i = 0; i < 4; i++) sch_f[d][i] = 1'b0;
        cnt[d] = 0;
        if (rst) last[d] = 0;
      end else if (din_en) begin
        for (int i = 7; i > 0; i--) hist[d][i] = hist[d][i-1];
        hist[d][0] = int'(din) - 512;
        if (cnt[d] == decim[d] - 1) begin
          sch_f[d][(cyc + 3) % 4] = 1'b1;
          sch_v[d][(cyc + 3) % 4] = filt(d);
          cnt[d] = 0;
        end else begin
          cnt[d]++;
        end
      end
      if (sch_f[d][cyc % 4]) begin
        exp_en[d] = 1;
        last[d] = sch_v[d][cyc % 4];
        sch_f[d][cyc % 4] = 1'b0;
      end else begin
        exp_en[d] = 0;
      end
      exp_dout[d] = last[d];
    end
    if (rst) armed = 1'b1;
  end

  task automatic chk(input string nm, input int act, input int expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s cyc=%0d actual=%0d expected=%0d", nm, cyc, act, expv);
    end
  endtask

  // Per-cycle comparison on the falling edge, plus capture of strobed outputs.
  always @(negedge clk) begin
    if (armed) begin
      chk("dout_en_d1", int'(bus1.dout_en), exp_en[0]);
      chk("dout_d1", int'(bus1.dout), exp_dout[0]);
      chk("dout_en_d4", int'(bus4.dout_en), exp_en[1]);
      chk("dout_d4", int'(bus4.dout), exp_dout[1]);
      if (bus1.dout_en) begin
        cap1.push_back(int'(bus1.dout));
        capc1.push_back(cyc);
      end
      if (bus4.dout_en) cap4.push_back(int'(bus4.dout));
    end
  end

  task automatic step(input logic [9:0] d, input logic e, input logic c, input logic r);
    din = d;
    din_en = e;
    clr = c;
    rst = r;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_cap(input string nm, input int which, input int idx, input int expv);
    int act;
    act = -99999;
    if (which == 1 && idx >= 0 && idx < cap1.size()) act = cap1[idx];
    if (which == 4 && idx >= 0 && idx < cap4.size()) act = cap4[idx];
    chk(nm, act, expv);
  endtask

  task automatic clear_caps();
    cap1.delete();
    cap4.delete();
    capc1.delete();
  endtask

  int dc_seq [8] = '{8, 24, 56, 128, 200, 232, 248, 256};
  int imp_seq [9] = '{16, 32, 64, 144, 144, 64, 32, 16, 0};
  int acc_cyc;

  initial begin
    din = 10'd512; din_en = 1'b0; clr = 1'b0; rst = 1'b1;

    // Reset held two cycles with din_en toggling
    step(10'd768, 1'b1, 1'b0, 1'b1);
    step(10'd768, 1'b0, 1'b0, 1'b1);
    clear_caps();

    // DC step from reset
    step(10'd768, 1'b1, 1'b0, 1'b0);
    acc_cyc = cyc;
    for (int i = 0; i < 11; i++) step(10'd768, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) chk_cap($sformatf("dc_step_%0d", i), 1, i, dc_seq[i]);
    chk("dc_first_latency", (capc1.size() > 0) ? capc1[0] - acc_cyc : -1, 3);
    chk_cap("dc_decim4_0", 4, 0, 128);
    chk_cap("dc_decim4_1", 4, 1, 256);

    // Impulse after a flush
    step(10'd512, 1'b0, 1'b1, 1'b0);
    clear_caps();
    step(10'd1023, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 12; i++) step(10'd512, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 9; i++) chk_cap($sformatf("impulse_%0d", i), 1, i, imp_seq[i]);

    // Full scale both polarities
    for (int i = 0; i < 12; i++) step(10'd1023, 1'b1, 1'b0, 1'b0);
    chk_cap("full_pos", 1, cap1.size() - 1, 511);
    for (int i = 0; i < 12; i++) step(10'd0, 1'b1, 1'b0, 1'b0);
    chk_cap("full_neg", 1, cap1.size() - 1, -512);

    // 50% gapped input after flush: DECIM=4 emits once per four accepted samples
    step(10'd512, 1'b0, 1'b1, 1'b0);
    clear_caps();
    for (int i = 0; i < 16; i++) step(10'd768, (i % 2) == 0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(10'd768, 1'b0, 1'b0, 1'b0);
    chk("gap_decim4_count", cap4.size(), 2);
    chk_cap("gap_decim4_0", 4, 0, 128);
    chk_cap("gap_decim4_1", 4, 1, 256);

    // Flush mid-stream together with a sample
    for (int i = 0; i < 10; i++) step(10'd768, 1'b1, 1'b0, 1'b0);
    step(10'd768, 1'b1, 1'b1, 1'b0);
    clear_caps();
    for (int i = 0; i < 8; i++) step(10'd768, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) chk_cap($sformatf("clr_restart_%0d", i), 1, i, dc_seq[i]);

    // Reset mid-stream, then a stream with varied samples
    step(10'd300, 1'b1, 1'b0, 1'b1);
    step(10'd300, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 30; i++) step(10'((i * 97 + 13) % 1024), (i % 3) != 2, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) step(10'd512, 1'b0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/dds_fir_decim.md
DDS_FIR_DECIM -- requirements
Module: dds_fir_decim

Interface
REQ-001 Parameter DECIM, default 4, range 1..16: output decimation factor in accepted input samples.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset; synchronous and active-high.
REQ-004 din  input  10  DDS sample; unsigned offset binary, 512 = zero.
REQ-005 din_en  input  1  sample strobe; din is valid on each rising edge where din_en=1.
REQ-006 clr  input  1  synchronous flush of filter history, pipeline and decimation phase.
REQ-007 dout  output  10  filtered sample, two's complement signed.
REQ-008 dout_en  output  1  one-cycle strobe; dout is valid in every cycle where dout_en=1.

Function
REQ-009 Input conversion SHALL invert din[9] to form signed x = din-512, range -512..511.
REQ-010 Each accepted sample SHALL shift x into an 8-entry delay line x0 (newest) .. x7 (oldest); the delay line SHALL hold when din_en=0.
REQ-011 Fixed symmetric coefficients SHALL be h0..h7 = 2,4,8,18,18,8,4,2 (sum 64, unity DC gain).
REQ-012 Stage 1 SHALL pre-add symmetric pairs (x0+x7, x1+x6, x2+x5, x3+x4) at 11 bits signed.
REQ-013 Stage 2 SHALL form acc = 2*p0 + 4*p1 + 8*p2 + 18*p3 at 17 bits signed, with no truncation.
REQ-014 Stage 3 SHALL compute dout = (acc+32) >>> 6 (arithmetic shift, round-half-up).
REQ-015 Result range SHALL be -512..511 for all inputs: full scale 511 gives 511 and -512 gives -512, so no saturation logic is required.
REQ-016 Each stage SHALL carry a valid bit; stages SHALL advance every cycle, and bubbles SHALL propagate as valid=0.
REQ-017 Latency: for a sample accepted at rising edge k that is selected for output, dout_en=1 and the corresponding dout SHALL appear in the cycle after edge k+3.
REQ-018 Throughput SHALL be one sample per clock; back-to-back din_en SHALL be accepted with no stall and no backpressure.
REQ-019 Decimation counter SHALL count accepted samples 0..DECIM-1.
REQ-020 Only the sample accepted when the counter equals DECIM-1 SHALL produce dout_en; the counter SHALL then wrap to 0.
REQ-021 With DECIM=1, every accepted sample SHALL produce an output.
REQ-022 dout SHALL hold its last value between dout_en pulses.
REQ-023 clr=1 SHALL zero the delay line, all stage valid bits and the decimation counter on that edge.
REQ-024 In-flight samples SHALL be dropped on clr, with no dout_en for them; dout SHALL retain its value.
REQ-025 clr and din_en asserted together: clr wins and the sample is discarded.
REQ-026 rst and clr asserted together: rst behaviour applies.
REQ-027 Samples accepted after clr SHALL see zeros in the history, identical to behaviour after reset.

Reset
REQ-028 On rst=1 at a rising edge: delay line = 0 (signed zero), all valid bits = 0, decimation counter = 0, dout = 0, dout_en = 0.
REQ-029 rst asserted mid-stream SHALL abort all in-flight samples; dout_en SHALL be 0 in every cycle while rst=1.
REQ-030 The first din_en SHALL be honoured on the first edge after rst deasserts.

Verification
REQ-031 Reset: hold rst=1 for 2 cycles with din_en toggling -> dout=0, dout_en=0 throughout; no spurious strobe after release.
REQ-032 DC step, DECIM=1: din=768 on every cycle from reset -> dout sequence 8, 24, 56, 128, 200, 232, 248, then 256 steady; first dout_en 3 edges after first accept.
REQ-033 Impulse, DECIM=1: one sample din=1023 then din=512 continuously -> dout 16, 32, 64, 144, 144, 64, 32, 16, then 0.
REQ-034 Full scale, DECIM=1: din=1023 continuous -> steady dout=511; din=0 continuous -> steady dout=-512.
REQ-035 Decimation, DECIM=4: continuous din_en -> dout_en every 4th cycle; with din_en gapped at 50% -> one dout_en per 4 accepted samples, at latency 3 from the 4th sample.
REQ-036 clr mid-stream, DECIM=1: steady 768 input, then clr=1 for 1 cycle together with din_en -> no dout_en for the 3 in-flight samples or the clr-cycle sample; following outputs restart 8, 24, 56, ...
